// File: rtl/gpr_wb_arbiter.sv
// GPR write-back arbiter: datapath requests (A) compete with a 2-entry
// FIFO of secondary-unit offers (B); the FIFO is force-granted after
// STARVE_LIMIT consecutive losses.
// Ports: clk/rst; AReq/ASel/AData -> AAck; BValid/BSel/BData -> BReady;
// WE/WeSel/WData registered GPR write; QSel1/2 -> Hazard1/2; Count.
module gpr_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AReq,
  input  logic [4:0]  ASel,
  input  logic [31:0] AData,
  output logic        AAck,
  input  logic        BValid,
  input  logic [4:0]  BSel,
  input  logic [31:0] BData,
  output logic        BReady,
  output logic        WE,
  output logic [4:0]  WeSel,
  output logic [31:0] WData,
  input  logic [4:0]  QSel1,
  input  logic [4:0]  QSel2,
  output logic        Hazard1,
  output logic        Hazard2,
  output logic [1:0]  Count
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [4:0]    sel_q  [2];
  logic [31:0]   data_q [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [SW-1:0] starve;

  logic          fifo_ne;
  logic          force_b;
  logic          grant_a;
  logic          grant_b;
  logic          push;
  logic [4:0]    head_sel;
  logic [4:0]    tail_sel;
  logic [4:0]    win_sel;
  logic [31:0]   win_data;

  always_comb begin
    fifo_ne  = (Count != 2'd0);
    force_b  = fifo_ne && (starve == LIM);
    grant_a  = !rst && AReq && !force_b;
    grant_b  = !rst && fifo_ne && !grant_a;
    BReady   = !rst && (Count != 2'd2);
    push     = BValid && BReady;
    AAck     = grant_a;
    head_sel = sel_q[rd_ptr];
    tail_sel = sel_q[rd_ptr ^ 1'b1];
    win_sel  = grant_a ? ASel  : head_sel;
    win_data = grant_a ? AData : data_q[rd_ptr];
  end

  // Second entry is only valid when the FIFO is full.
  always_comb begin
    Hazard1 = (QSel1 != 5'd0) &&
      ((fifo_ne && head_sel == QSel1) ||
       (Count == 2'd2 && tail_sel == QSel1) ||
       (WE && WeSel == QSel1));
    Hazard2 = (QSel2 != 5'd0) &&
      ((fifo_ne && head_sel == QSel2) ||
       (Count == 2'd2 && tail_sel == QSel2) ||
       (WE && WeSel == QSel2));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sel_q[wr_ptr]  <= BSel;
      data_q[wr_ptr] <= BData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      Count  <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (grant_b)
        rd_ptr <= ~rd_ptr;
      unique case ({push, grant_b})
        2'b10:   Count <= Count + 2'd1;
        2'b01:   Count <= Count - 2'd1;
        default: Count <= Count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (grant_b || !fifo_ne) begin
      starve <= '0;
    end else if (starve != LIM) begin
      starve <= starve + 1'b1;
    end
  end

  // Writes to x0 are still consumed but never raise WE.
  always_ff @(posedge clk) begin
    if (rst) begin
      WE    <= 1'b0;
      WeSel <= 5'd0;
      WData <= 32'd0;
    end else if (grant_a || grant_b) begin
      WE    <= (win_sel != 5'd0);
      WeSel <= win_sel;
      WData <= win_data;
    end else begin
      WE <= 1'b0;
    end
  end

endmodule
